// File: rtl/fv_dup_seq_pkg.sv
// Shared types and helpers for the duplicate-instruction sequencer.
package fv_dup_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ORIG  = 3'd1,
    S_DUP   = 3'd2,
    S_DRAIN = 3'd3,
    S_SYNC  = 3'd4,
    S_DONE  = 3'd5
  } fv_dup_seq_state_t;

  // Width of a write total able to hold depth*ports writes, plus headroom bit.
  function automatic int fv_cnt_w(input int depth, input int ports);
    return $clog2(depth * ports) + 1;
  endfunction

  // Number of set bits in a (zero-extended) write mask.
  function automatic int fv_popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fv_dup_wr_tally.sv
// Per-class RF write accumulator: popcount of the class mask added each
// enabled cycle into a total that sticks at all-ones instead of wrapping.
module fv_dup_wr_tally
  import fv_dup_seq_pkg::*;
#(
  parameter int NUM_WR_PORTS = 2,
  parameter int CNT_W        = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    cnt_en,
  input  logic [NUM_WR_PORTS-1:0] wr_mask,
  output logic [CNT_W-1:0]        total
);

  logic [CNT_W:0] sum;

  // Extra top bit of the sum flags overflow, which clamps the total.
  always_comb begin
    sum = {1'b0, total} + (CNT_W+1)'(fv_popcount(32'(wr_mask)));
  end

  // Accumulate with saturation; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (reset || clr)
      total <= '0;
    else if (cnt_en)
      total <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/fv_dup_seq_ctrl.sv
// Sequencer for the duplicate-instruction self-consistency check: issues
// originals, then duplicates, drains until write totals balance, then syncs.
module fv_dup_seq_ctrl
  import fv_dup_seq_pkg::*;
#(
  parameter int NUM_WR_PORTS  = 2,
  parameter int MAX_BMC_DEPTH = 32,
  parameter int MAX_ORIG_LEN  = 8,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = fv_cnt_w(MAX_BMC_DEPTH, NUM_WR_PORTS),
  parameter int LEN_W         = $clog2(MAX_ORIG_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        orig_len,
  input  logic                    issue_valid,
  input  logic [NUM_WR_PORTS-1:0] rf_write_en,
  input  logic [NUM_WR_PORTS-1:0] rf_write_is_dup,
  input  logic                    rf_any_locked,
  input  logic                    pipeline_empty,
  output logic                    issue_stall,
  output logic                    issue_dup_mode,
  output logic                    dup_enable,
  output logic                    fv_dup_sync_ready,
  output logic                    dup_done,
  output logic                    err_timeout,
  output logic [CNT_W-1:0]        orig_writes,
  output logic [CNT_W-1:0]        dup_writes
);

  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  fv_dup_seq_state_t state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  issue_nxt;
  logic [LEN_W-1:0]  len_clamp;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              fire;
  logic              drain_ok;
  logic              tally_clr;
  logic              tally_en;

  // Handshake, length clamp and drain-exit condition on registered totals.
  always_comb begin
    fire      = issue_valid && !issue_stall;
    issue_nxt = issue_cnt + LEN_W'(1);
    if (orig_len == '0)
      len_clamp = LEN_W'(1);
    else if (orig_len > LEN_W'(MAX_ORIG_LEN))
      len_clamp = LEN_W'(MAX_ORIG_LEN);
    else
      len_clamp = orig_len;
    drain_ok  = (orig_writes == dup_writes) && !rf_any_locked && pipeline_empty;
    tally_clr = (state == S_IDLE) && start;
    tally_en  = (state != S_IDLE);
  end

  // Sequencer FSM; DONE is terminal until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len         <= '0;
      issue_cnt   <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len       <= len_clamp;
          issue_cnt <= '0;
          tmo_cnt   <= '0;
          state     <= S_ORIG;
        end
        S_ORIG: if (fire) begin
          if (issue_nxt == len) begin
            issue_cnt <= '0;
            state     <= S_DUP;
          end else begin
            issue_cnt <= issue_nxt;
          end
        end
        S_DUP: if (fire) begin
          if (issue_nxt == len) begin
            issue_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            issue_cnt <= issue_nxt;
          end
        end
        S_DRAIN: begin
          // A balanced drain beats a coincident timeout.
          if (drain_ok) begin
            state <= S_SYNC;
          end else if (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_SYNC:  state <= S_DONE;
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    issue_stall       = 1'b1;
    issue_dup_mode    = 1'b0;
    dup_enable        = (state != S_IDLE);
    fv_dup_sync_ready = (state == S_SYNC);
    dup_done          = (state == S_DONE);
    case (state)
      S_ORIG:  issue_stall = 1'b0;
      S_DUP: begin
        issue_stall    = 1'b0;
        issue_dup_mode = 1'b1;
      end
      default: issue_stall = 1'b1;
    endcase
  end

  fv_dup_wr_tally #(.NUM_WR_PORTS(NUM_WR_PORTS), .CNT_W(CNT_W)) u_orig_tally (
    .clk     (clk),
    .reset   (reset),
    .clr     (tally_clr),
    .cnt_en  (tally_en),
    .wr_mask (rf_write_en & ~rf_write_is_dup),
    .total   (orig_writes)
  );

  fv_dup_wr_tally #(.NUM_WR_PORTS(NUM_WR_PORTS), .CNT_W(CNT_W)) u_dup_tally (
    .clk     (clk),
    .reset   (reset),
    .clr     (tally_clr),
    .cnt_en  (tally_en),
    .wr_mask (rf_write_en & rf_write_is_dup),
    .total   (dup_writes)
  );

endmodule

// File: tb/tb_fv_dup_seq_ctrl.sv
// Directed bench for fv_dup_seq_ctrl: a vector table for the basic flow plus
// hand-written sequences for timeout, lock gating, length/start, saturation
// and reset corner cases.
module tb_fv_dup_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] orig_len;
  logic       issue_valid;
  logic [1:0] rf_write_en;
  logic [1:0] rf_write_is_dup;
  logic       rf_any_locked;
  logic       pipeline_empty;
  logic       issue_stall;
  logic       issue_dup_mode;
  logic       dup_enable;
  logic       fv_dup_sync_ready;
  logic       dup_done;
  logic       err_timeout;
  logic [6:0] orig_writes;
  logic [6:0] dup_writes;

  int n_vec = 0;
  int n_bad = 0;

  fv_dup_seq_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .orig_len          (orig_len),
    .issue_valid       (issue_valid),
    .rf_write_en       (rf_write_en),
    .rf_write_is_dup   (rf_write_is_dup),
    .rf_any_locked     (rf_any_locked),
    .pipeline_empty    (pipeline_empty),
    .issue_stall       (issue_stall),
    .issue_dup_mode    (issue_dup_mode),
    .dup_enable        (dup_enable),
    .fv_dup_sync_ready (fv_dup_sync_ready),
    .dup_done          (dup_done),
    .err_timeout       (err_timeout),
    .orig_writes       (orig_writes),
    .dup_writes        (dup_writes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [3:0]  ln;
    logic        iv;
    logic [1:0]  we;
    logic [1:0]  wd;
    logic        lk;
    logic        pe;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[12];

  // Packed expectation: {stall, dup_mode, enable, sync, done, err, ow, dw}.
  function automatic logic [19:0] ex(input logic s, input logic m, input logic e,
                                     input logic y, input logic d, input logic r,
                                     input int ow, input int dw);
    return {s, m, e, y, d, r, 7'(ow), 7'(dw)};
  endfunction

  task automatic drive(input logic st, input logic [3:0] ln, input logic iv,
                       input logic [1:0] we, input logic [1:0] wd,
                       input logic lk, input logic pe);
    start = st; orig_len = ln; issue_valid = iv;
    rf_write_en = we; rf_write_is_dup = wd;
    rf_any_locked = lk; pipeline_empty = pe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [19:0] exp);
    logic [19:0] act;
    act = {issue_stall, issue_dup_mode, dup_enable, fv_dup_sync_ready,
           dup_done, err_timeout, orig_writes, dup_writes};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  // Apply inputs, clock once, check the post-edge outputs.
  task automatic step(input string nm, input logic st, input logic [3:0] ln,
                      input logic iv, input logic [1:0] we, input logic [1:0] wd,
                      input logic lk, input logic pe, input logic [19:0] exp);
    drive(st, ln, iv, we, wd, lk, pe);
    tick();
    chk(nm, exp);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk(nm, ex(1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
  endtask

  initial begin
    // Basic flow, len 3: writes land one cycle after each fire.
    tbl[0]  = '{0, 0, 0, 2'b01, 2'b00, 0, 0, ex(1,0,0,0,0,0,0,0)}; // idle write ignored
    tbl[1]  = '{1, 3, 1, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0)}; // -> ORIG
    tbl[2]  = '{0, 0, 1, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0)};
    tbl[3]  = '{0, 0, 1, 2'b01, 2'b00, 0, 0, ex(0,0,1,0,0,0,1,0)};
    tbl[4]  = '{0, 0, 1, 2'b01, 2'b00, 0, 0, ex(0,1,1,0,0,0,2,0)}; // -> DUP
    tbl[5]  = '{0, 0, 1, 2'b01, 2'b00, 0, 0, ex(0,1,1,0,0,0,3,0)};
    tbl[6]  = '{0, 0, 1, 2'b01, 2'b01, 0, 0, ex(0,1,1,0,0,0,3,1)};
    tbl[7]  = '{0, 0, 1, 2'b01, 2'b01, 0, 0, ex(1,0,1,0,0,0,3,2)}; // -> DRAIN
    tbl[8]  = '{0, 0, 0, 2'b01, 2'b01, 0, 0, ex(1,0,1,0,0,0,3,3)}; // 3/2 seen
    tbl[9]  = '{0, 0, 0, 2'b00, 2'b00, 0, 1, ex(1,0,1,1,0,0,3,3)}; // -> SYNC
    tbl[10] = '{0, 0, 0, 2'b00, 2'b00, 0, 1, ex(1,0,1,0,1,0,3,3)}; // -> DONE
    tbl[11] = '{1, 3, 1, 2'b00, 2'b00, 0, 1, ex(1,0,1,0,1,0,3,3)}; // start ignored

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("reset_state", ex(1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      step($sformatf("basic[%0d]", i), tbl[i].st, tbl[i].ln, tbl[i].iv,
           tbl[i].we, tbl[i].wd, tbl[i].lk, tbl[i].pe, tbl[i].exp);

    // Imbalance timeout: 2 orig vs 1 dup writes never balance.
    do_reset("rst_before_tmo");
    step("tmo_start", 1, 2, 0, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0));
    step("tmo_o1",    0, 0, 1, 2'b11, 2'b00, 0, 0, ex(0,0,1,0,0,0,2,0));
    step("tmo_o2",    0, 0, 1, 2'b00, 2'b00, 0, 0, ex(0,1,1,0,0,0,2,0));
    step("tmo_d1",    0, 0, 1, 2'b01, 2'b01, 0, 0, ex(0,1,1,0,0,0,2,1));
    step("tmo_d2",    0, 0, 1, 2'b00, 2'b00, 0, 0, ex(1,0,1,0,0,0,2,1));
    for (int i = 1; i <= 16; i++)
      step($sformatf("tmo_drain[%0d]", i), 0, 0, 0, 2'b00, 2'b00, 0, 1,
           (i < 16) ? ex(1,0,1,0,0,0,2,1) : ex(1,0,1,0,1,1,2,1));
    step("tmo_sticky", 1, 2, 1, 2'b00, 2'b00, 0, 1, ex(1,0,1,0,1,1,2,1));
    do_reset("rst_clears_err");

    // Lock gating: balanced 0/0 but locked for 5 cycles.
    step("lk_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0));
    step("lk_orig",  0, 0, 1, 2'b00, 2'b00, 0, 0, ex(0,1,1,0,0,0,0,0));
    step("lk_dup",   0, 0, 1, 2'b00, 2'b00, 0, 0, ex(1,0,1,0,0,0,0,0));
    for (int i = 0; i < 5; i++)
      step($sformatf("lk_hold[%0d]", i), 0, 0, 0, 2'b00, 2'b00, 1, 1,
           ex(1,0,1,0,0,0,0,0));
    step("lk_release", 0, 0, 0, 2'b00, 2'b00, 0, 1, ex(1,0,1,1,0,0,0,0));

    // Zero length acts as 1; a start during DUP is ignored.
    do_reset("rst_before_zl");
    step("zl_start",   1, 0, 0, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0));
    step("zl_orig",    0, 0, 1, 2'b00, 2'b00, 0, 0, ex(0,1,1,0,0,0,0,0));
    step("zl_restart", 1, 5, 0, 2'b00, 2'b00, 0, 0, ex(0,1,1,0,0,0,0,0));
    step("zl_dup",     0, 0, 1, 2'b00, 2'b00, 0, 0, ex(1,0,1,0,0,0,0,0));

    // Dual-port duplicate writes, run into saturation at 127.
    do_reset("rst_before_sat");
    step("sat_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0));
    for (int k = 1; k <= 66; k++)
      step($sformatf("sat[%0d]", k), 0, 0, 0, 2'b11, 2'b11, 0, 0,
           ex(0,0,1,0,0,0,0, (2*k > 127) ? 127 : 2*k));

    // Reset in DRAIN returns everything to the reset state.
    do_reset("rst_before_mid");
    step("mid_start", 1, 1, 0, 2'b00, 2'b00, 0, 0, ex(0,0,1,0,0,0,0,0));
    step("mid_orig",  0, 0, 1, 2'b01, 2'b00, 0, 0, ex(0,1,1,0,0,0,1,0));
    step("mid_dup",   0, 0, 1, 2'b00, 2'b00, 0, 0, ex(1,0,1,0,0,0,1,0));
    step("mid_drain", 0, 0, 0, 2'b00, 2'b00, 1, 1, ex(1,0,1,0,0,0,1,0));
    do_reset("mid_reset");
    step("mid_idle",  0, 0, 1, 2'b11, 2'b01, 0, 1, ex(1,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fv_dup_seq_ctrl.md
# fv_dup_seq_ctrl

Sequencer for the duplicate-instruction self-consistency flow. It starts a check on `start` and issues `orig_len` original instructions, then the same number of duplicates. It then drains the pipeline until original and duplicate RF write totals match with no register locked, and finally pulses `fv_dup_sync_ready` and raises `dup_done`. It sits between the core fetch/issue stage and the RF write-tracking monitor, and drives `dup_enable`, `dup_done` and `fv_dup_sync_ready` for that monitor.

## Interface
- `NUM_WR_PORTS`, 2, number of RF write ports observed.
- `MAX_BMC_DEPTH`, 32, bound used to size the write totals.
- `MAX_ORIG_LEN`, 8, maximum original-instruction count per check.
- `DRAIN_TIMEOUT`, 16, maximum cycles allowed in DRAIN.
- `CNT_W`, derived: $clog2(MAX_BMC_DEPTH*NUM_WR_PORTS)+1.
- `LEN_W`, derived: $clog2(MAX_ORIG_LEN+1).

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a check; sampled only in IDLE.
- `orig_len`  in  LEN_W  original-instruction count, captured on start.
- `issue_valid`  in  1  core offers an instruction this cycle.
- `rf_write_en`  in  NUM_WR_PORTS  per-port RF write strobe.
- `rf_write_is_dup`  in  NUM_WR_PORTS  per-port flag: destination is a duplicate register (pre-decoded, excludes r0/r0').
- `rf_any_locked`  in  1  OR of all RF register locks.
- `pipeline_empty`  in  1  no instruction in flight.
- `issue_stall`  out  1  blocks issue.
- `issue_dup_mode`  out  1  0 = issue original, 1 = issue duplicate.
- `dup_enable`  out  1  check active.
- `fv_dup_sync_ready`  out  1  one-cycle sync pulse.
- `dup_done`  out  1  sticky completion flag.
- `err_timeout`  out  1  sticky: drain timed out.
- `orig_writes`, `dup_writes`  out  CNT_W each  running write totals.

## Operation
- Issue handshake: fire = `issue_valid` && !`issue_stall`.
- FSM states: IDLE, ORIG, DUP, DRAIN, SYNC, DONE.
- IDLE:
  - Outputs: `issue_stall`=1, `dup_enable`=0.
  - On `start`: capture len = max(`orig_len`, 1) clamped to MAX_ORIG_LEN, clear the totals and issue counter, go to ORIG.
- ORIG:
  - Outputs: `issue_stall`=0, `issue_dup_mode`=0.
  - Count fires; the fire that reaches len moves to DUP and clears the issue counter.
- DUP:
  - Outputs: `issue_dup_mode`=1.
  - Count fires; the fire that reaches len moves to DRAIN.
- DRAIN:
  - Outputs: `issue_stall`=1.
  - Leave condition: `orig_writes`==`dup_writes` && !`rf_any_locked` && `pipeline_empty`, evaluated on registered totals → SYNC.
  - Otherwise the timeout counter increments. At DRAIN_TIMEOUT cycles go to DONE and set `err_timeout`.
- SYNC: `fv_dup_sync_ready`=1 for exactly one cycle, then DONE.
- DONE:
  - Outputs: `dup_done`=1, `issue_stall`=1.
  - Stays here until `reset`; `start` is ignored.
- `dup_enable`=1 in ORIG, DUP, DRAIN, SYNC and DONE.
- Write totals:
  - Each cycle outside IDLE, `orig_writes` += popcount(en & ~is_dup) and `dup_writes` += popcount(en & is_dup).
  - Both totals saturate at all-ones; a saturated total never wraps.
  - Writes in IDLE are not counted.
- `start` outside IDLE has no effect.

## Timing
- Every state transition takes effect on the clk edge after its condition.
- All outputs are registered or decoded from state; no input→output combinational path except `issue_stall` = f(state).
- Reset values: state IDLE; `issue_stall`=1; all other outputs 0; counters 0.
- `reset` asserted in any state returns the block to IDLE at the next edge and clears the sticky flags.
- Latencies:
  - `start` → ORIG: 1 cycle.
  - Last DUP fire → DRAIN: 1 cycle.
  - Drain condition true → `fv_dup_sync_ready`: 1 cycle later.
  - `fv_dup_sync_ready` → `dup_done`: 1 cycle.
- A write and the final duplicate fire in the same cycle: the write is counted, and DRAIN sees the updated totals one cycle later.
- If the drain condition and the timeout occur in the same cycle, the drain condition wins (SYNC, no error).

## Structure
- Package `fv_dup_seq_pkg` contains:
  - the state enum `fv_dup_seq_state_t`;
  - the width function `fv_cnt_w(depth, ports)`;
  - a popcount function.
- Sub-module `fv_dup_wr_tally`:
  - per-class popcount plus a saturating CNT_W accumulator with a clear input;
  - instantiated twice, once for original writes and once for duplicate writes.

## Test plan
- **Basic flow.** `orig_len`=3, `issue_valid` held at 1, each instruction writes 1 port one cycle later.
  - ORIG lasts 3 cycles, DUP lasts 3, DRAIN ends when totals = 3/3.
  - `fv_dup_sync_ready` pulses once; `dup_done`=1 the next cycle.
- **Imbalance timeout.** After DUP, original writes = 2 and duplicate writes = 1.
  - `err_timeout` sets after 16 DRAIN cycles; `dup_done`=1; no sync pulse.
- **Lock gating.** Totals equal but `rf_any_locked`=1 for 5 cycles.
  - SYNC is entered exactly 1 cycle after the lock drops.
- **Zero length and start while busy.**
  - `orig_len`=0 behaves as 1.
  - A second `start` during DUP is ignored.
- **Dual port and saturation.** Both ports write duplicates simultaneously.
  - `dup_writes` increments by 2.
  - When forced to all-ones it stays at all-ones.
- **Reset mid-operation.** `reset` in DRAIN.
  - Next cycle: IDLE, `issue_stall`=1, every other output 0.
